// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC select and pipeline freeze/flush control with deferred redirects
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_STALL = 16,
    parameter int          CNT_W     = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        load_use_i,
    input  logic        mem_stall_i,
    output logic [31:0] pc_next_o,
    output logic        pc_write_o,
    output logic        stall_o,
    output logic        hazard_o,
    output logic        if_id_write_o,
    output logic        if_flush_o,
    output logic        id_ex_bubble_o,
    output logic        timeout_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] L_MAX_STALL = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] L_CNT_ONE   = CNT_W'(1);

    state_t             r_state;
    logic               r_pend_valid;
    logic [31:0]        r_pend_target;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_timeout;

    state_t             w_state_next;
    logic               w_pend_valid_next;
    logic [31:0]        w_pend_target_next;
    logic [CNT_W-1:0]   w_stall_cnt_next;
    logic               w_timeout_next;

    logic               w_redirect;
    logic [31:0]        w_redirect_target;
    logic [31:0]        w_pc_seq;
    logic               w_active;

    assign w_redirect        = jump_i | branch_taken_i;
    assign w_redirect_target = jump_i ? jump_target_i : branch_target_i;
    assign w_pc_seq          = pc_i + 32'd4;
    assign w_active          = start_i && (r_state == S_RUN || r_state == S_MEM_WAIT);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state       <= S_IDLE;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
            r_stall_cnt   <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pend_valid  <= w_pend_valid_next;
            r_pend_target <= w_pend_target_next;
            r_stall_cnt   <= w_stall_cnt_next;
            r_timeout     <= w_timeout_next;
        end
    end

    always_comb begin
        pc_next_o          = pc_i;
        pc_write_o         = 1'b0;
        stall_o            = 1'b0;
        hazard_o           = 1'b0;
        if_id_write_o      = 1'b0;
        if_flush_o         = 1'b0;
        id_ex_bubble_o     = 1'b0;
        w_state_next       = r_state;
        w_pend_valid_next  = r_pend_valid;
        w_pend_target_next = r_pend_target;
        w_stall_cnt_next   = r_stall_cnt;
        w_timeout_next     = r_timeout;

        if (!w_active) begin
            pc_next_o = RESET_PC;
            stall_o   = 1'b1;
            if (!start_i) begin
                w_state_next      = S_IDLE;
                w_pend_valid_next = 1'b0;
                w_stall_cnt_next  = '0;
            end else begin
                w_state_next = S_RUN;
            end
        end else if (mem_stall_i) begin
            // Whole pipe frozen; only the oldest redirect seen during the stall is kept.
            stall_o      = 1'b1;
            w_state_next = S_MEM_WAIT;
            if (r_state == S_RUN) begin
                w_stall_cnt_next = L_CNT_ONE;
            end else if (r_stall_cnt >= L_MAX_STALL) begin
                w_stall_cnt_next = L_MAX_STALL;
            end else begin
                w_stall_cnt_next = r_stall_cnt + L_CNT_ONE;
            end
            if (w_stall_cnt_next == L_MAX_STALL) begin
                w_timeout_next = 1'b1;
            end
            if (w_redirect && !r_pend_valid) begin
                w_pend_valid_next  = 1'b1;
                w_pend_target_next = w_redirect_target;
            end
        end else begin
            w_state_next     = S_RUN;
            w_stall_cnt_next = '0;
            if (r_pend_valid) begin
                // Deferred redirect is older than anything in ID now, so it wins.
                pc_next_o         = r_pend_target;
                pc_write_o        = 1'b1;
                if_id_write_o     = 1'b1;
                if_flush_o        = 1'b1;
                w_pend_valid_next = 1'b0;
            end else if (w_redirect) begin
                pc_next_o     = w_redirect_target;
                pc_write_o    = 1'b1;
                if_id_write_o = 1'b1;
                if_flush_o    = 1'b1;
            end else if (load_use_i) begin
                hazard_o       = 1'b1;
                id_ex_bubble_o = 1'b1;
            end else begin
                pc_next_o     = w_pc_seq;
                pc_write_o    = 1'b1;
                if_id_write_o = 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
    assign state_o   = r_state;

endmodule
